// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the execute-stage multiply/divide unit.
package ex_muldiv_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/ex_muldiv_div_step.sv
// Combinational slice of DIV_BITS restoring-division steps. The dividend is
// shifted out MSB-first while quotient bits are shifted into its LSB end.
module ex_muldiv_div_step #(
  parameter int DATA_W   = 32,
  parameter int DIV_BITS = 1
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] dvd_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] dvd_o
);

  logic [DATA_W-1:0] rem_s [DIV_BITS+1];
  logic [DATA_W-1:0] dvd_s [DIV_BITS+1];

  assign rem_s[0] = rem_i;
  assign dvd_s[0] = dvd_i;

  for (genvar gi = 0; gi < DIV_BITS; gi++) begin : g_step
    logic [DATA_W:0] shifted;
    logic [DATA_W:0] diff;
    assign shifted = {rem_s[gi], dvd_s[gi][DATA_W-1]};
    assign diff    = shifted - {1'b0, divisor_i};
    // Borrow out means the trial subtract failed: keep the shifted remainder.
    assign rem_s[gi+1] = diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
    assign dvd_s[gi+1] = {dvd_s[gi][DATA_W-2:0], ~diff[DATA_W]};
  end

  assign rem_o = rem_s[DIV_BITS];
  assign dvd_o = dvd_s[DIV_BITS];

endmodule

// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the execute stage. Operands are held
// as magnitudes; signs are re-applied once when the result is registered.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MUL_BITS = 8,
  parameter int DIV_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] opdata1_i,
  input  logic [DATA_W-1:0] opdata2_i,
  input  logic              annul_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              ready_o,
  output logic              busy_o,
  output logic              stallreq_o
);

  localparam int MUL_STEPS = DATA_W / MUL_BITS;
  localparam int DIV_STEPS = DATA_W / DIV_BITS;
  localparam int CNT_W     = $clog2(DATA_W + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic                neg_res_q, neg_res_d;
  logic                neg_rem_q, neg_rem_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;

  logic                    sgn_op;
  logic [DATA_W-1:0]       abs1, abs2;
  logic [MUL_BITS-1:0]     digit;
  logic [DATA_W+MUL_BITS-1:0] mul_part;
  logic [2*DATA_W-1:0]     mul_next;
  logic [DATA_W-1:0]       rem_next, quo_next;

  assign sgn_op = op_is_signed(op_i);
  assign abs1   = (sgn_op && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign abs2   = (sgn_op && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

  // Shift-add multiply: add the digit product into the upper half, then shift
  // the whole accumulator right so the next digit lines up with the same slot.
  assign digit    = b_q[MUL_BITS-1:0];
  assign mul_part = (DATA_W+MUL_BITS)'(acc_q[2*DATA_W-1:DATA_W])
                  + (DATA_W+MUL_BITS)'(a_q) * (DATA_W+MUL_BITS)'(digit);
  assign mul_next = {mul_part, acc_q[DATA_W-1:MUL_BITS]};

  ex_muldiv_div_step #(
    .DATA_W   (DATA_W),
    .DIV_BITS (DIV_BITS)
  ) u_div_step (
    .rem_i     (acc_q[2*DATA_W-1:DATA_W]),
    .dvd_i     (acc_q[DATA_W-1:0]),
    .divisor_i (b_q),
    .rem_o     (rem_next),
    .dvd_o     (quo_next)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          a_d       = abs1;
          b_d       = abs2;
          neg_res_d = sgn_op & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
          neg_rem_d = sgn_op & opdata1_i[DATA_W-1];
          if (!op_is_div(op_i)) begin
            state_d = ST_MUL;
            cnt_d   = CNT_W'(MUL_STEPS);
            acc_d   = '0;
          end else if (opdata2_i == '0) begin
            state_d = ST_DONE;
            hi_d    = opdata1_i;
            lo_d    = '1;
          end else begin
            state_d = ST_DIV;
            cnt_d   = CNT_W'(DIV_STEPS);
            acc_d   = {{DATA_W{1'b0}}, abs1};
          end
        end
      end
      ST_MUL: begin
        acc_d = mul_next;
        b_d   = b_q >> MUL_BITS;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d      = ST_DONE;
          {hi_d, lo_d} = neg_res_q ? -mul_next : mul_next;
        end
      end
      ST_DIV: begin
        acc_d = {rem_next, quo_next};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
          lo_d    = neg_res_q ? -quo_next : quo_next;
          hi_d    = neg_rem_q ? -rem_next : rem_next;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // A flush cancels any in-flight work and must not disturb visible results.
    if (annul_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
  assign ready_o    = (state_q == ST_DONE);
  assign busy_o     = (state_q == ST_MUL) || (state_q == ST_DIV);
  assign stallreq_o = busy_o || ((state_q == ST_IDLE) && start_i && !annul_i);

endmodule

// File: tb/tb_ex_muldiv.sv
// Randomized and directed bench for ex_muldiv at two parameter sets, checked
// against an arithmetic reference model.
`timescale 1ns/1ps
module tb_ex_muldiv;

  localparam int WA = 32, MBA = 8, DBA = 1;
  localparam int WB = 16, MBB = 4, DBB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start_r [2];
  logic        annul_r [2];
  logic [1:0]  op_r    [2];
  logic [31:0] a_r     [2];
  logic [31:0] b_r     [2];
  logic [31:0] hi_w    [2];
  logic [31:0] lo_w    [2];
  logic        ready_w [2];
  logic        busy_w  [2];
  logic        stall_w [2];

  logic [WA-1:0] hi_a, lo_a;
  logic [WB-1:0] hi_b, lo_b;
  logic ready_a, busy_a, stall_a, ready_b, busy_b, stall_b;

  int n_assert = 0;
  int n_fail   = 0;

  ex_muldiv #(.DATA_W(WA), .MUL_BITS(MBA), .DIV_BITS(DBA)) dut_a (
    .clk(clk), .rst(rst), .start_i(start_r[0]), .op_i(op_r[0]),
    .opdata1_i(a_r[0]), .opdata2_i(b_r[0]), .annul_i(annul_r[0]),
    .hi_o(hi_a), .lo_o(lo_a), .ready_o(ready_a), .busy_o(busy_a),
    .stallreq_o(stall_a)
  );

  ex_muldiv #(.DATA_W(WB), .MUL_BITS(MBB), .DIV_BITS(DBB)) dut_b (
    .clk(clk), .rst(rst), .start_i(start_r[1]), .op_i(op_r[1]),
    .opdata1_i(a_r[1][WB-1:0]), .opdata2_i(b_r[1][WB-1:0]), .annul_i(annul_r[1]),
    .hi_o(hi_b), .lo_o(lo_b), .ready_o(ready_b), .busy_o(busy_b),
    .stallreq_o(stall_b)
  );

  assign hi_w[0] = hi_a;            assign lo_w[0] = lo_a;
  assign hi_w[1] = {16'h0, hi_b};   assign lo_w[1] = {16'h0, lo_b};
  assign ready_w[0] = ready_a;      assign ready_w[1] = ready_b;
  assign busy_w[0]  = busy_a;       assign busy_w[1]  = busy_b;
  assign stall_w[0] = stall_a;      assign stall_w[1] = stall_b;

  function automatic int width_of(input int u);
    return (u == 0) ? WA : WB;
  endfunction

  function automatic longint sx(input logic [31:0] v, input int w);
    longint r;
    r = longint'(v) & ((longint'(1) << w) - 1);
    if (v[w-1]) r = r - (longint'(1) << w);
    return r;
  endfunction

  // Reference: plain integer arithmetic on w-bit values.
  function automatic void model(input int w, input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] hi,
                                output logic [31:0] lo);
    longint mask, ua, ub, sa, sb;
    logic [63:0] p;
    mask = (longint'(1) << w) - 1;
    ua = longint'(a) & mask;
    ub = longint'(b) & mask;
    sa = sx(a, w);
    sb = sx(b, w);
    p  = (op == 2'b00) ? 64'(sa * sb) : 64'(ua * ub);
    if (op[1] == 1'b0) begin
      lo = 32'(p & 64'(mask));
      hi = 32'((p >> w) & 64'(mask));
    end else if (ub == 0) begin
      hi = 32'(ua);
      lo = 32'(mask);
    end else if (op == 2'b11) begin
      lo = 32'(ua / ub);
      hi = 32'(ua % ub);
    end else if (sa == -(longint'(1) << (w - 1)) && sb == -1) begin
      lo = 32'(ua);
      hi = 32'h0;
    end else begin
      lo = 32'((sa / sb) & mask);
      hi = 32'((sa % sb) & mask);
    end
  endfunction

  function automatic int exp_lat(input int u, input logic [1:0] op, input logic [31:0] b);
    int w;
    w = width_of(u);
    if (op[1] == 1'b0) return w / ((u == 0) ? MBA : MBB) + 1;
    if ((longint'(b) & ((longint'(1) << w) - 1)) == 0) return 1;
    return w / ((u == 0) ? DBA : DBB) + 1;
  endfunction

  // Issue one op, follow it to ready_o, check flags, latency and result.
  // Returns at the negedge inside the DONE cycle.
  task automatic run_op(input int u, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input string tag);
    logic [31:0] eh, el;
    int cyc, lat;
    model(width_of(u), op, a, b, eh, el);
    lat = exp_lat(u, op, b);
    @(negedge clk);
    op_r[u] = op; a_r[u] = a; b_r[u] = b; start_r[u] = 1'b1;
    #1;
    n_assert++;
    if (stall_w[u] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s stall_c0 u%0d: got %b want 1", tag, u, stall_w[u]);
    end
    @(negedge clk);
    start_r[u] = 1'b0;
    op_r[u] = 2'($urandom); a_r[u] = $urandom; b_r[u] = $urandom;
    #1;
    cyc = 1;
    while (ready_w[u] !== 1'b1 && cyc < 100) begin
      n_assert++;
      if (stall_w[u] !== 1'b1 || busy_w[u] !== 1'b1) begin
        n_fail++;
        $display("FAIL %s busy_stall u%0d cyc%0d: got %b/%b want 1/1", tag, u, cyc,
                 busy_w[u], stall_w[u]);
      end
      @(negedge clk);
      cyc++;
    end
    n_assert++;
    if (cyc !== lat) begin
      n_fail++;
      $display("FAIL %s latency u%0d: got %0d want %0d", tag, u, cyc, lat);
    end
    n_assert++;
    if (hi_w[u] !== eh) begin
      n_fail++;
      $display("FAIL %s hi u%0d: got %h want %h", tag, u, hi_w[u], eh);
    end
    n_assert++;
    if (lo_w[u] !== el) begin
      n_fail++;
      $display("FAIL %s lo u%0d: got %h want %h", tag, u, lo_w[u], el);
    end
    n_assert++;
    if (stall_w[u] !== 1'b0 || busy_w[u] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_flags u%0d: stall=%b busy=%b want 0/0", tag, u,
               stall_w[u], busy_w[u]);
    end
    $display("txn %s u%0d op=%0d a=%h b=%h -> hi=%h lo=%h lat=%0d", tag, u, op, a, b,
             hi_w[u], lo_w[u], cyc);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      n_assert++;
      if (hi_w[u] !== 32'h0 || lo_w[u] !== 32'h0 || ready_w[u] !== 1'b0 ||
          busy_w[u] !== 1'b0 || stall_w[u] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset u%0d: hi=%h lo=%h rdy=%b busy=%b stall=%b want all 0", u,
                 hi_w[u], lo_w[u], ready_w[u], busy_w[u], stall_w[u]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_directed(input int u);
    logic [1:0]  ops [5];
    logic [31:0] as  [5];
    logic [31:0] bs  [5];
    logic [31:0] hs  [5];
    logic [31:0] ls  [5];
    logic [31:0] a_use;
    ops = '{2'b00, 2'b11, 2'b10, 2'b10, 2'b11};
    as  = '{32'hFFFFFFFD, 32'd100, 32'hFFFFFFF9, 32'h80000000, 32'd5};
    bs  = '{32'd5, 32'd7, 32'd2, 32'hFFFFFFFF, 32'd0};
    hs  = '{32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'h0, 32'd5};
    ls  = '{32'hFFFFFFF1, 32'd14, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF};
    for (int i = 0; i < 5; i++) begin
      a_use = (as[i] == 32'h80000000) ? (32'h1 << (width_of(u) - 1)) : as[i];
      run_op(u, ops[i], a_use, bs[i], "directed");
      if (u == 0) begin
        n_assert++;
        if (hi_w[0] !== hs[i] || lo_w[0] !== ls[i]) begin
          n_fail++;
          $display("FAIL directed_const #%0d: got %h/%h want %h/%h", i, hi_w[0], lo_w[0],
                   hs[i], ls[i]);
        end
      end
      @(negedge clk);
      n_assert++;
      if (ready_w[u] !== 1'b0) begin
        n_fail++;
        $display("FAIL ready_pulse u%0d #%0d: got %b want 0", u, i, ready_w[u]);
      end
    end
  endtask

  task automatic test_annul();
    logic saw_ready;
    run_op(0, 2'b01, 32'd2, 32'd3, "annul_pre");
    @(negedge clk);
    op_r[0] = 2'b11; a_r[0] = 32'd9; b_r[0] = 32'd4; start_r[0] = 1'b1;
    @(negedge clk);
    start_r[0] = 1'b0;
    repeat (9) @(negedge clk);
    annul_r[0] = 1'b1;
    @(negedge clk);
    annul_r[0] = 1'b0;
    #1;
    n_assert++;
    if (busy_w[0] !== 1'b0 || ready_w[0] !== 1'b0 || hi_w[0] !== 32'h0 || lo_w[0] !== 32'd6) begin
      n_fail++;
      $display("FAIL annul_div: busy=%b rdy=%b hi=%h lo=%h want 0 0 0 6", busy_w[0],
               ready_w[0], hi_w[0], lo_w[0]);
    end
    saw_ready = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ready_w[0] === 1'b1) saw_ready = 1'b1;
    end
    n_assert++;
    if (saw_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL annul_no_ready: got ready pulse, want none");
    end
    op_r[0] = 2'b00; start_r[0] = 1'b1; annul_r[0] = 1'b1;
    #1;
    n_assert++;
    if (stall_w[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL annul_idle_stall: got %b want 0", stall_w[0]);
    end
    @(negedge clk);
    start_r[0] = 1'b0; annul_r[0] = 1'b0;
    #1;
    n_assert++;
    if (busy_w[0] !== 1'b0 || stall_w[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL annul_idle_start: busy=%b stall=%b want 0/0", busy_w[0], stall_w[0]);
    end
  endtask

  task automatic test_reset_mid();
    run_op(0, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, "rst_pre");
    @(negedge clk);
    op_r[0] = 2'b00; a_r[0] = 32'd77; b_r[0] = 32'd3; start_r[0] = 1'b1;
    @(negedge clk);
    start_r[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_assert++;
    if (hi_w[0] !== 32'h0 || lo_w[0] !== 32'h0 || ready_w[0] !== 1'b0 ||
        busy_w[0] !== 1'b0 || stall_w[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: hi=%h lo=%h rdy=%b busy=%b stall=%b want all 0",
               hi_w[0], lo_w[0], ready_w[0], busy_w[0], stall_w[0]);
    end
  endtask

  task automatic test_back_to_back(input int u);
    run_op(u, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, "b2b_mul");
    // Start held high through DONE must not be taken until IDLE.
    op_r[u] = 2'b10; a_r[u] = 32'd7; b_r[u] = 32'hFFFFFFFE; start_r[u] = 1'b1;
    run_op(u, 2'b10, 32'd7, 32'hFFFFFFFE, "b2b_div");
  endtask

  task automatic test_random(input int u, input int n);
    logic [1:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < n; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 5) == 0) b = 32'h0;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
      run_op(u, op, a, b, "random");
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int u = 0; u < 2; u++) begin
      start_r[u] = 1'b0; annul_r[u] = 1'b0; op_r[u] = 2'b00;
      a_r[u] = 32'h0; b_r[u] = 32'h0;
    end
    rst = 1'b1;
    test_reset();
    for (int u = 0; u < 2; u++) test_directed(u);
    test_annul();
    test_reset_mid();
    for (int u = 0; u < 2; u++) test_back_to_back(u);
    for (int u = 0; u < 2; u++) test_random(u, 25);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
